// File: rtl/axi_bridge_mp_pkg.sv
// Shared encodings for the multi-port cache-to-AXI3 bridge: request types,
// AXI constants and the read/write FSM state types.
package axi_bridge_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam logic [3:0] WR_ID_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACT  = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_bytes);
        return addr & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping; the pointer moves past a port only when the owner says so.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          upd,
    input  logic [PW-1:0] upd_idx,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [PW-1:0] ptr;
    logic          found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (upd_idx == PW'(N - 1)) ? '0 : upd_idx + PW'(1);
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i >= int'(ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i < int'(ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/axi_bridge_mp.sv
// Bridges NUM_RD cache read clients and one write-back client onto one AXI3
// master; one read and one write in flight, reads to a line being written stall.
module axi_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int         NUM_RD     = 2,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] WR_ID      = WR_ID_DEFAULT
) (
    input  logic                    aclk,
    input  logic                    areset,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [NUM_RD-1:0]       rd_req,
    input  logic [3*NUM_RD-1:0]     rd_type,
    input  logic [32*NUM_RD-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_rdy,
    output logic [NUM_RD-1:0]       ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy
);

    localparam int         LINE_BYTES = LINE_WORDS * 4;
    localparam int         LSB        = $clog2(LINE_BYTES);
    localparam int         PW         = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [7:0] LINE_LEN   = 8'(LINE_WORDS - 1);

    rd_state_t r_state;
    wr_state_t w_state;

    logic [NUM_RD-1:0]       grant;
    logic                    any_req;
    logic                    ptr_upd;
    logic [PW-1:0]           port_q;
    logic [PW-1:0]           win_idx;
    logic [31:0]             win_addr;
    logic [2:0]              win_type;
    logic                    hazard;
    logic                    rd_ok;
    logic                    rd_accept;
    logic                    wr_accept;
    logic [4:0]              left_q;
    logic [32*LINE_WORDS-1:0] wbuf_q;
    logic                    unused_ok;

    assign unused_ok = &{1'b0, rresp, bid, bresp};

    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'h0;
    assign awcache = 4'h0;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;
    assign awid    = WR_ID;
    assign wid     = WR_ID;

    rr_arbiter #(.N(NUM_RD), .PW(PW)) u_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (rd_req),
        .upd     (ptr_upd),
        .upd_idx (port_q),
        .grant   (grant),
        .any     (any_req)
    );

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_type = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (grant[i]) begin
                win_idx  = PW'(i);
                win_addr = rd_addr[i*32 +: 32];
                win_type = rd_type[i*3 +: 3];
            end
        end
    end

    // A read stalls if its line is owned by the write path now or from this edge on.
    assign wr_rdy    = (w_state == W_IDLE) && !areset;
    assign wr_accept = wr_req && wr_rdy;
    assign hazard    = ((w_state != W_IDLE) && (win_addr[31:LSB] == awaddr[31:LSB])) ||
                       (wr_accept && (win_addr[31:LSB] == wr_addr[31:LSB]));
    assign rd_ok     = (r_state == R_IDLE) && !hazard && !areset;
    assign rd_rdy    = grant & {NUM_RD{rd_ok}};
    assign rd_accept = any_req && rd_ok;
    assign ptr_upd   = (r_state == R_DATA) && rvalid && rlast;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            ret_valid[i] = rvalid && rready && (rid == 4'(i));
        end
    end
    assign ret_last = rvalid && rready && rlast;
    assign ret_data = rready ? rdata : 32'h0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            port_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_accept) begin
                        port_q  <= win_idx;
                        arid    <= 4'(win_idx);
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                        if (win_type == TYPE_LINE) begin
                            araddr <= line_align(win_addr, LINE_BYTES);
                            arlen  <= LINE_LEN;
                            arsize <= SIZE_4B;
                        end else begin
                            araddr <= win_addr;
                            arlen  <= 8'd0;
                            arsize <= {1'b0, win_type[1:0]};
                        end
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Line buffer shifts down one word per accepted W beat; word 0 goes straight to wdata.
    always_ff @(posedge aclk) begin
        if (wr_accept) begin
            wbuf_q <= wr_data >> 32;
        end else if ((w_state == W_ACT) && wvalid && wready && !wlast) begin
            wbuf_q <= wbuf_q >> 32;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            wlast   <= 1'b0;
            left_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        wdata   <= wr_data[31:0];
                        w_state <= W_ACT;
                        if (wr_type == TYPE_LINE) begin
                            awaddr <= line_align(wr_addr, LINE_BYTES);
                            awlen  <= LINE_LEN;
                            awsize <= SIZE_4B;
                            wstrb  <= 4'hF;
                            left_q <= 5'(LINE_WORDS - 1);
                            wlast  <= (LINE_WORDS == 1);
                        end else begin
                            awaddr <= wr_addr;
                            awlen  <= 8'd0;
                            awsize <= {1'b0, wr_type[1:0]};
                            wstrb  <= wr_wstrb;
                            left_q <= 5'd0;
                            wlast  <= 1'b1;
                        end
                    end
                end
                W_ACT: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                        end else begin
                            wdata  <= wbuf_q[31:0];
                            left_q <= left_q - 5'd1;
                            wlast  <= (left_q == 5'd1);
                        end
                    end
                    if ((!awvalid || awready) && (!wvalid || (wready && wlast))) begin
                        bready  <= 1'b1;
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp: reads, round-robin, line write, RAW stall
// and asynchronous reset, with AR/W expectations queued at stimulus time.
module tb_axi_bridge_mp;
    import axi_bridge_pkg::*;

    localparam int NUM_RD     = 2;
    localparam int LINE_WORDS = 4;

    logic aclk = 1'b0;
    logic areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [NUM_RD-1:0]        rd_req;
    logic [3*NUM_RD-1:0]      rd_type;
    logic [32*NUM_RD-1:0]     rd_addr;
    logic [NUM_RD-1:0]        rd_rdy;
    logic [NUM_RD-1:0]        ret_valid;
    logic                     ret_last;
    logic [31:0]              ret_data;
    logic                     wr_req;
    logic [2:0]               wr_type;
    logic [31:0]              wr_addr;
    logic [3:0]               wr_wstrb;
    logic [32*LINE_WORDS-1:0] wr_data;
    logic                     wr_rdy;

    axi_bridge_mp #(.NUM_RD(NUM_RD), .LINE_WORDS(LINE_WORDS), .WR_ID(4'hF)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    ar_t         ar_q[$];
    logic [31:0] w_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic ar_t exp_ar(input int port, input logic [2:0] t, input logic [31:0] a);
        ar_t r;
        r.id = 4'(port);
        if (t == 3'b100) begin
            r.addr = a & 32'hFFFF_FFF0;
            r.len  = 8'd3;
            r.size = 3'd2;
        end else begin
            r.addr = a;
            r.len  = 8'd0;
            r.size = {1'b0, t[1:0]};
        end
        return r;
    endfunction

    // Waits for the grant, checks the AR beat against the queued expectation, then returns beats.
    task automatic serve_read(input int port, input logic [2:0] t, input logic [31:0] a,
                              input int beats, input bit drop);
        ar_t e;
        int  n;
        logic [31:0] d;
        n = 0;
        #1;
        while (rd_rdy == '0 && n < 40) begin
            step();
            #1;
            n++;
        end
        chk("rd_rdy_grant", 64'(rd_rdy), 64'(1) << port);
        ar_q.push_back(exp_ar(port, t, a));
        step();
        if (drop) rd_req[port] = 1'b0;
        n = 0;
        while (!arvalid && n < 20) begin
            step();
            n++;
        end
        chk("arvalid", 64'(arvalid), 64'(1));
        e = ar_q.pop_front();
        chk("arid", 64'(arid), 64'(e.id));
        chk("araddr", 64'(araddr), 64'(e.addr));
        chk("arlen", 64'(arlen), 64'(e.len));
        chk("arsize", 64'(arsize), 64'(e.size));
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("rready", 64'(rready), 64'(1));
        for (int b = 0; b < beats; b++) begin
            d      = 32'hD000_0000 | (32'(port) << 8) | 32'(b);
            rvalid = 1'b1;
            rid    = 4'(port);
            rdata  = d;
            rlast  = (b == beats - 1);
            #1;
            chk("ret_valid", 64'(ret_valid), 64'(1) << port);
            chk("ret_data", 64'(ret_data), 64'(d));
            chk("ret_last", 64'(ret_last), 64'(b == beats - 1));
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;

        step();
        step();
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_wvalid", 64'(wvalid), 64'(0));
        chk("rst_rready", 64'(rready), 64'(0));
        chk("rst_bready", 64'(bready), 64'(0));
        chk("rst_rd_rdy", 64'(rd_rdy), 64'(0));
        chk("rst_wr_rdy", 64'(wr_rdy), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("const_arburst", 64'(arburst), 64'(1));
        areset = 1'b0;
        step();

        // Byte read on port 0
        rd_req = 2'b01; rd_type[2:0] = 3'b000; rd_addr[31:0] = 32'h0000_0003;
        serve_read(0, 3'b000, 32'h0000_0003, 1, 1'b1);

        // Line read on port 1
        rd_req = 2'b10; rd_type[5:3] = 3'b100; rd_addr[63:32] = 32'h1C00_0014;
        serve_read(1, 3'b100, 32'h1C00_0014, 4, 1'b1);

        // Round-robin with both ports requesting continuously
        rd_type = {3'b010, 3'b010};
        rd_addr = {32'h0000_0080, 32'h0000_0040};
        rd_req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve_read(k % 2, 3'b010, (k % 2) ? 32'h0000_0080 : 32'h0000_0040, 1, 1'b0);
        end
        rd_req = 2'b00;
        step();

        // Line write with wready held low
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0100; wr_wstrb = 4'h0;
        wr_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        #1;
        chk("wr_rdy_idle", 64'(wr_rdy), 64'(1));
        for (int i = 0; i < 4; i++) w_q.push_back(32'hA0 + 32'(i));
        step();
        wr_req = 1'b0;
        chk("awvalid", 64'(awvalid), 64'(1));
        chk("wvalid", 64'(wvalid), 64'(1));
        chk("awaddr", 64'(awaddr), 64'(32'h100));
        chk("awlen", 64'(awlen), 64'(3));
        chk("awsize", 64'(awsize), 64'(2));
        chk("awid", 64'(awid), 64'(4'hF));
        chk("wr_rdy_busy", 64'(wr_rdy), 64'(0));
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("awvalid_drop", 64'(awvalid), 64'(0));
        chk("wvalid_hold", 64'(wvalid), 64'(1));
        chk("bready_early", 64'(bready), 64'(0));
        step();
        chk("bready_early2", 64'(bready), 64'(0));

        // Read to another line proceeds while the write is in flight
        rd_req = 2'b10; rd_type[5:3] = 3'b010; rd_addr[63:32] = 32'h0000_0200;
        serve_read(1, 3'b010, 32'h0000_0200, 1, 1'b1);
        chk("bready_w_pending", 64'(bready), 64'(0));

        // Read to the line being written must stall
        rd_req = 2'b01; rd_type[2:0] = 3'b010; rd_addr[31:0] = 32'h0000_010C;
        #1;
        chk("raw_stall_a", 64'(rd_rdy), 64'(0));
        step();
        #1;
        chk("raw_stall_b", 64'(rd_rdy), 64'(0));
        wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("wdata", 64'(wdata), 64'(w_q.pop_front()));
            chk("wstrb", 64'(wstrb), 64'(4'hF));
            chk("wlast", 64'(wlast), 64'(b == 3));
            chk("raw_stall_w", 64'(rd_rdy), 64'(0));
            step();
            #1;
        end
        wready = 1'b0;
        chk("bready_after_w", 64'(bready), 64'(1));
        chk("wvalid_done", 64'(wvalid), 64'(0));
        chk("raw_stall_b_wait", 64'(rd_rdy), 64'(0));
        bvalid = 1'b1;
        #1;
        chk("raw_stall_bvalid", 64'(rd_rdy), 64'(0));
        step();
        bvalid = 1'b0;
        #1;
        chk("wr_rdy_back", 64'(wr_rdy), 64'(1));
        chk("raw_release", 64'(rd_rdy), 64'(1));
        serve_read(0, 3'b010, 32'h0000_010C, 1, 1'b1);

        // Asynchronous reset in the middle of a read address phase
        rd_req = 2'b10; rd_type[5:3] = 3'b010; rd_addr[63:32] = 32'h0000_0300;
        #1;
        chk("pre_rst_grant", 64'(rd_rdy), 64'(2));
        step();
        rd_req = 2'b00;
        chk("pre_rst_arvalid", 64'(arvalid), 64'(1));
        areset = 1'b1;
        #1;
        chk("async_arvalid", 64'(arvalid), 64'(0));
        chk("async_araddr", 64'(araddr), 64'(0));
        chk("async_rready", 64'(rready), 64'(0));
        chk("async_wr_rdy", 64'(wr_rdy), 64'(0));
        chk("async_ret_valid", 64'(ret_valid), 64'(0));
        step();
        areset = 1'b0;
        rd_type = {3'b010, 3'b010};
        rd_addr = {32'h0000_0080, 32'h0000_0040};
        rd_req  = 2'b11;
        serve_read(0, 3'b010, 32'h0000_0040, 1, 1'b0);
        rd_req = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_bridge_mp.md
Name: axi_bridge_mp

Overview:
- Parametrised successor to the core's cache-to-AXI bridge.
- Connects NUM_RD cache read clients (icache, dcache, future ports such as an uncached or prefetch port) and one dcache write-back client to a single AXI3 master port.
- Arbitrates the read clients round-robin. Issues one read and one write transaction concurrently, with programmable line length.
- Blocks any read whose cache line matches an in-flight write-back (read-after-write hazard).

Parameters:
- NUM_RD, 2, number of read clients, 1..8. Read client i uses arid = i.
- LINE_WORDS, 4, 32-bit words per cache line, one of 1, 2, 4, 8, 16. Line bursts use arlen/awlen = LINE_WORDS-1.
- WR_ID, 4'hF, constant awid/wid. Must not be less than NUM_RD.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  4/2/1
- bready  out  1
- rd_req  in  NUM_RD  per-client read request
- rd_type  in  3*NUM_RD  per client: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line
- rd_addr  in  32*NUM_RD
- rd_rdy  out  NUM_RD  request accepted when rd_req[i] && rd_rdy[i]
- ret_valid  out  NUM_RD
- ret_last  out  1
- ret_data  out  32  broadcast to all clients
- wr_req  in  1
- wr_type  in  3  same encoding as rd_type
- wr_addr  in  32
- wr_wstrb  in  4  used for non-line writes only
- wr_data  in  32*LINE_WORDS  word 0 in LSBs
- wr_rdy  out  1

Behaviour:
- Reset (async, areset=1): all valid/ready/rdy/ret outputs = 0; address/data outputs = 0; read FSM in R_IDLE, write FSM in W_IDLE; round-robin pointer = 0.
- Constant outputs: arburst = awburst = 2'b01, arlock = awlock = 0, arcache = awcache = 0, arprot = awprot = 0.
- Read FSM states R_IDLE, R_AR, R_DATA.
  - In R_IDLE, the arbiter picks the first requesting port at or after the pointer (wrapping). Only that port sees rd_rdy = 1, combinationally, unless it has a hazard.
  - On acceptance in cycle t: latch port, address and type; go to R_AR. arvalid = 1 from cycle t+1.
  - Line type: arlen = LINE_WORDS-1, arsize = 2, araddr aligned down to the line. Other types: arlen = 0, arsize = type[1:0], araddr unmodified.
  - arvalid && arready -> R_DATA; rready = 1 while in R_DATA.
  - ret_valid[i] = rvalid && rready && rid == i. ret_data = rdata; ret_last = rlast.
  - Beat with rlast -> R_IDLE; the pointer moves to (granted port + 1) mod NUM_RD.
  - Earliest re-acceptance is the cycle after rlast.
- Write FSM states W_IDLE, W_ACT, W_B.
  - wr_rdy = 1 only in W_IDLE.
  - On acceptance: latch address, type, data and strobe into the line buffer; go to W_ACT. awvalid = wvalid = 1 from the next cycle.
  - AW and W complete independently; each drops after its own handshake.
  - W beats are taken from the buffer word by word. wlast is on beat LINE_WORDS-1 for line writes, or on the single beat otherwise.
  - wstrb = 4'hF for line writes, else the latched wr_wstrb.
  - Once both AW and the last W beat are done -> W_B with bready = 1. bvalid -> W_IDLE.
  - rresp and bresp are ignored.
- RAW hazard: the arbiter winner gets rd_rdy = 0 when its rd_addr[31:log2(LINE_WORDS*4)] equals the line address of either:
  - the write FSM's latched line, while the write FSM is not in W_IDLE; or
  - wr_addr, when a write is being accepted in the same cycle.
  - The pointer does not advance while stalled. The read is accepted in the cycle the write FSM is back in W_IDLE.
- Reads and writes proceed fully concurrently when there is no hazard.
- Requests are latched, so client inputs may change after acceptance without affecting the transaction.

Decomposition:
- Package axi_bridge_pkg holds:
  - rd/wr type encodings: TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE;
  - AXI constants: BURST_INCR, SIZE_4B;
  - read and write FSM state encodings;
  - WR_ID default.
- Sub-module rr_arbiter, parametrised on N, provides the grant one-hot, an any-request flag and a pointer-update input.

Test Plan:
- Reset: assert areset mid-burst with arvalid = 1 -> all valid/rdy outputs 0 immediately, no clock edge needed. After release, a new request is granted to port 0 first.
- Line read: NUM_RD = 2, LINE_WORDS = 4, port 1 rd_type = 3'b100, addr = 0x1C000014 -> araddr = 0x1C000010, arlen = 3, arsize = 2, arid = 1. Four rdata beats give ret_valid = 2'b10 on each beat and ret_last on the 4th.
- Round-robin: both ports request word reads continuously -> grants alternate 0, 1, 0, 1. Each transaction has arlen = 0 and arsize = 2.
- Line write: wr_type = line, addr = 0x00000100, data words 0xA0..0xA3, wready held low 3 cycles -> awlen = 3. W beats carry 0xA0, 0xA1, 0xA2, 0xA3 with wstrb = F and wlast on the 4th. bready asserts only after both AW and W are done.
- RAW hazard: write to 0x100 in flight, port 0 reads 0x10C -> rd_rdy[0] stays 0 until bvalid. Read accepted the following cycle. A concurrent read to 0x200 is not blocked.
- Byte read: rd_type = 3'b000, addr = 0x3 -> arsize = 0, arlen = 0, araddr = 0x3.
